// File: rtl/fold_pkg.sv
// Shared defaults and state encoding for the phase-folding accumulator.
package fold_pkg;
    localparam int NBINS_DEF = 1024;
    localparam int DW_DEF    = 16;
    localparam int AW_DEF    = 32;
    localparam int BIN_W_DEF = $clog2(NBINS_DEF);

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DUMP  = 2'd2
    } state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction
endpackage

// File: rtl/profile_ram.sv
// Profile storage: one write port, one synchronous read port, 1-cycle read latency, no reset.
module profile_ram #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 32,
    parameter int ABITS = 10
) (
    input  logic             clk,
    input  logic             we,
    input  logic [ABITS-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [ABITS-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/fold_accumulator.sv
// Folds power samples into phase bins; sample write lands 2 edges after accept.
// Sample side never stalls (drops counted); dump output is valid/ready and stalls cleanly.
module fold_accumulator
    import fold_pkg::*;
#(
    parameter int NBINS = NBINS_DEF,
    parameter int DW    = DW_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sample_valid,
    input  logic [DW-1:0]            sample_data,
    input  logic [$clog2(NBINS)-1:0] bin_index,
    input  logic                     dump_req,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(NBINS)-1:0] out_bin,
    output logic [AW-1:0]            out_data,
    output logic                     out_last,
    output logic [15:0]              fold_count,
    output logic [15:0]              drop_count,
    output logic                     busy
);
    localparam int BW = $clog2(NBINS);
    localparam logic [BW-1:0] BIN_ONE  = BW'(1);
    localparam logic [BW-1:0] BIN_LAST = BW'(NBINS - 1);

    state_t        state, state_nxt;
    logic [BW-1:0] clr_idx, dump_idx, prev_bin;
    logic          have_prev, prime;
    logic          s1_vld, fwd_hit;
    logic [BW-1:0] s1_bin;
    logic [DW-1:0] s1_dat;
    logic [AW-1:0] fwd_val, rd_data, base, sum;
    logic [AW:0]   sum_ext;
    logic          accept, fire;
    logic          ram_we;
    logic [BW-1:0] ram_waddr, ram_raddr;
    logic [AW-1:0] ram_wdata;

    assign accept   = sample_valid && (state == ST_ACCUM);
    assign fire     = out_valid && out_ready;
    assign out_bin  = dump_idx;
    assign out_last = out_valid && (dump_idx == BIN_LAST);
    assign out_data = out_valid ? rd_data : '0;
    assign busy     = (state != ST_ACCUM);

    // A same-bin write landing on the read edge is not visible in rd_data; take the forwarded sum.
    always_comb begin
        base    = fwd_hit ? fwd_val : rd_data;
        sum_ext = {1'b0, base} + {{(AW + 1 - DW){1'b0}}, s1_dat};
        sum     = sum_ext[AW] ? '1 : sum_ext[AW-1:0];
    end

    always_comb begin
        ram_we    = s1_vld;
        ram_waddr = s1_bin;
        ram_wdata = sum;
        if (state == ST_CLEAR) begin
            ram_we    = 1'b1;
            ram_waddr = clr_idx;
            ram_wdata = '0;
        end
        // During a dump the read address runs one ahead on a handshake so rd_data tracks out_bin.
        if (state == ST_DUMP)
            ram_raddr = (fire && !out_last) ? dump_idx + BIN_ONE : dump_idx;
        else
            ram_raddr = bin_index;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_CLEAR: if (clr_idx == BIN_LAST) state_nxt = ST_ACCUM;
            ST_ACCUM: if (dump_req) state_nxt = ST_DUMP;
            ST_DUMP:  if (fire && out_last) state_nxt = ST_CLEAR;
            default:  state_nxt = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_CLEAR;
            clr_idx    <= '0;
            dump_idx   <= '0;
            out_valid  <= 1'b0;
            prime      <= 1'b0;
            s1_vld     <= 1'b0;
            s1_bin     <= '0;
            s1_dat     <= '0;
            fwd_hit    <= 1'b0;
            fwd_val    <= '0;
            have_prev  <= 1'b0;
            prev_bin   <= '0;
            fold_count <= '0;
            drop_count <= '0;
        end else begin
            state  <= state_nxt;
            s1_vld <= accept;
            if (accept) begin
                s1_bin    <= bin_index;
                s1_dat    <= sample_data;
                fwd_hit   <= s1_vld && (s1_bin == bin_index);
                fwd_val   <= sum;
                have_prev <= 1'b1;
                prev_bin  <= bin_index;
            end
            if (state == ST_CLEAR) begin
                clr_idx   <= clr_idx + BIN_ONE;
                have_prev <= 1'b0;
            end
            if (state != ST_CLEAR && state_nxt == ST_CLEAR)
                fold_count <= '0;
            else if (accept && have_prev && (bin_index < prev_bin))
                fold_count <= sat_inc16(fold_count);
            if (sample_valid && state != ST_ACCUM)
                drop_count <= sat_inc16(drop_count);
            // Two idle cycles at dump start let the last accepted update retire before bin 0 is read.
            if (state == ST_DUMP) begin
                if (!out_valid) begin
                    prime <= 1'b1;
                    if (prime) out_valid <= 1'b1;
                end else if (fire) begin
                    if (out_last) begin
                        out_valid <= 1'b0;
                        prime     <= 1'b0;
                        dump_idx  <= '0;
                    end else begin
                        dump_idx <= dump_idx + BIN_ONE;
                    end
                end
            end
        end
    end

    profile_ram #(.DEPTH(NBINS), .WIDTH(AW), .ABITS(BW)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (ram_raddr),
        .rdata (rd_data)
    );
endmodule

// File: doc/fold_accumulator.md
FOLD_ACCUMULATOR -- requirements
Module: fold_accumulator

Interface
REQ-001 SHALL have parameter NBINS, default 1024; number of phase bins, power of two.
REQ-002 SHALL have parameter DW, default 16; unsigned sample width.
REQ-003 SHALL have parameter AW, default 32; accumulator width per bin.
REQ-004 SHALL have port clk  in  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port sample_valid  in  1  sample and bin index present this cycle.
REQ-007 SHALL have port sample_data  in  DW  detected power sample, unsigned.
REQ-008 SHALL have port bin_index  in  log2(NBINS)  phase bin from time-phase stage.
REQ-009 SHALL have port dump_req  in  1  single-cycle request to stream and clear profile.
REQ-010 SHALL have port out_valid  out  1  profile word available.
REQ-011 SHALL have port out_ready  in  1  consumer accepts word.
REQ-012 SHALL have port out_bin  out  log2(NBINS)  bin of out_data.
REQ-013 SHALL have port out_data  out  AW  accumulated bin sum.
REQ-014 SHALL have port out_last  out  1  marks bin NBINS-1.
REQ-015 SHALL have port fold_count  out  16  completed phase wraps since last clear.
REQ-016 SHALL have port drop_count  out  16  samples discarded outside ACCUM.
REQ-017 SHALL have port busy  out  1  high in CLEAR or DUMP.

Function
REQ-018 SHALL implement states CLEAR, ACCUM, DUMP; reset enters CLEAR.
REQ-019 CLEAR SHALL write 0 to bins 0..NBINS-1, one per cycle, then go to ACCUM (NBINS cycles); it SHALL zero fold_count on entry.
REQ-020 In ACCUM, a sample SHALL be accepted when sample_valid=1; no backpressure on the sample side.
REQ-021 Accepted sample SHALL be added to bin[bin_index], zero-extended to AW; result written at the 2nd rising edge after acceptance.
REQ-022 Addition SHALL saturate at 2^AW-1.
REQ-023 Back-to-back accepts to the same bin (gap 0 or 1 cycle) SHALL accumulate exactly via write-to-read forwarding; no lost updates.
REQ-024 fold_count SHALL increment (saturating at 0xFFFF) when an accepted bin_index is less than the previous accepted bin_index; the first accept after clear never increments.
REQ-025 sample_valid=1 in CLEAR or DUMP SHALL increment drop_count (saturating at 0xFFFF), clear only by rst.
REQ-026 dump_req in ACCUM SHALL move to DUMP after in-flight updates retire (≤2 cycles); dump_req in CLEAR or DUMP SHALL be ignored.
REQ-027 DUMP SHALL present bins 0..NBINS-1 in order; one word transferred per cycle with out_valid=1 and out_ready=1.
REQ-028 out_bin/out_data/out_last SHALL hold stable while out_valid=1 and out_ready=0; full throughput when out_ready held high.
REQ-029 After the handshake with out_last=1, the block SHALL enter CLEAR.
REQ-030 out_valid SHALL be 0 outside DUMP.

Reset
REQ-031 rst SHALL force: state CLEAR at bin 0, out_valid=0, out_bin=0, out_data=0, out_last=0, fold_count=0, drop_count=0, busy=1, pipeline valids 0.
REQ-032 rst asserted mid-DUMP or mid-update SHALL abandon the operation; the profile is re-cleared before any accept.

Structure
REQ-033 A shared package fold_pkg SHALL hold NBINS, DW, AW defaults, bin index width and the state enum.
REQ-034 Profile storage SHALL be a sub-module profile_ram: NBINS x AW, one sync read port, one write port, 1-cycle read latency, no reset.

Verification
REQ-035 Reset, wait 1024 cycles -> busy falls at cycle 1024; a dump then yields 1024 words, all 0, out_last on bin 1023.
REQ-036 Samples 100 to bin 5 on 4 consecutive cycles, then dump -> bin 5 = 400, all others 0.
REQ-037 Bin 1023=7 then bin 0=3 then bin 2=1 -> fold_count=1; bins 1023/0/2 hold 7/3/1.
REQ-038 Preload bin 9 near full (65536 samples of 0xFFFF), add one more sample of 0xFFFF with AW=32 -> bin 9 = 0xFFFFFFFF.
REQ-039 Dump with out_ready toggled 1,0,0,1 pattern -> no word duplicated or lost, data stable while stalled; samples during dump raise drop_count by exactly the count sent.
REQ-040 rst at bin 500 of a dump -> out_valid=0 next cycle, full CLEAR, subsequent dump all zeros.
